// File: rtl/unpacker.sv
// Beat-to-element unpacker. It takes wide beats with byte strobes and emits
// the leading fully-strobed W-bit slots one per cycle, in order from slot 0.
// Elements within a beat are produced at full rate. When the last slot is
// consumed, the next beat can load in the same cycle, so there is no bubble.
module unpacker #(
   parameter int W         = 16,
   parameter int BEAT_W    = 128,
   parameter int LSB_FIRST = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [BEAT_W-1:0]   s_data,
   input  logic [BEAT_W/8-1:0] s_strb,
   input  logic                s_last,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [W-1:0]        m_data,
   output logic                m_last,
   output logic                err
);

   localparam int BPE   = W / 8;
   localparam int BPB   = BEAT_W / 8;
   localparam int EPB   = BEAT_W / W;
   localparam int IDX_W = (EPB > 1) ? $clog2(EPB) : 1;
   localparam int CNT_W = $clog2(EPB + 1);

   // Reject geometries where elements do not tile bytes or beats exactly.
   if (W <= 0 || (W % 8) != 0) begin : g_bad_w
      $error("unpacker: W must be a positive multiple of 8");
   end
   if (BEAT_W < W || (BEAT_W % W) != 0) begin : g_bad_beat_w
      $error("unpacker: BEAT_W must be a multiple of W");
   end

   typedef enum logic {
      S_EMPTY,
      S_EMIT
   } state_t;

   state_t             state_q, state_d;
   logic [BEAT_W-1:0]  data_q,  data_d;
   logic               last_q,  last_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               err_q,   err_d;

   logic [CNT_W-1:0]   in_cnt;
   logic [BPB-1:0]     in_mask;
   logic               in_bad;
   logic               in_run;
   logic               last_slot;
   logic               load;

   // Lowest byte index of slot k inside a beat.
   function automatic int slot_byte(input int k);
      return (LSB_FIRST != 0) ? k * BPE : BPB - (k + 1) * BPE;
   endfunction

   // Classify the incoming beat: count the leading full slots, and flag any
   // strobe bit that lies outside those slots.
   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      in_cnt  = '0;
      in_mask = '0;
      in_run  = 1'b1;
      for (int k = 0; k < EPB; k++) begin
         if (in_run && (&s_strb[slot_byte(k) +: BPE])) begin
            in_cnt                      = in_cnt + CNT_W'(1);
            in_mask[slot_byte(k) +: BPE] = '1;
         end else begin
            in_run = 1'b0;
         end
      end
      in_bad = (in_cnt == '0) || (|(s_strb & ~in_mask));
   end

   assign last_slot = (CNT_W'(idx_q) == cnt_q - CNT_W'(1));

   // Output view of the held beat. It reads as zero whenever nothing is presented.
   assign m_valid = (state_q == S_EMIT);
   assign m_data  = (state_q == S_EMIT) ? data_q[slot_byte(32'(idx_q)) * 8 +: W] : '0;
   assign m_last  = (state_q == S_EMIT) && last_q && last_slot;
   assign err     = err_q;

   // Next state, handshake and beat load. Strobes are fully summarised by cnt
   // and err at accept time, so only data and last need to be held.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      last_d  = last_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      s_ready = 1'b0;
      load    = 1'b0;

      unique case (state_q)
         S_EMPTY: begin
            s_ready = 1'b1;
            load    = s_valid;
         end
         S_EMIT: begin
            if (m_ready) begin
               if (!last_slot) begin
                  idx_d = idx_q + IDX_W'(1);
               end else begin
                  s_ready = 1'b1;
                  if (s_valid) load    = 1'b1;
                  else         state_d = S_EMPTY;
               end
            end
         end
         default: state_d = S_EMPTY;
      endcase

      if (load) begin
         if (in_bad) err_d = 1'b1;
         if (in_cnt == '0) begin
            // Nothing usable in this beat: drop it, including its last flag.
            state_d = S_EMPTY;
         end else begin
            state_d = S_EMIT;
            data_d  = s_data;
            last_d  = s_last;
            cnt_d   = in_cnt;
            idx_d   = '0;
         end
      end
   end

   // State and beat registers.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_EMPTY;
         // NOTE: the beat register is reset too, so no stale payload can leak after reset.
         data_q  <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_unpacker.sv
// Bench for unpacker. Two instances cover both slot orders. Beats are built
// from element bursts the way a packer lays them out, and every presented
// element is checked against the expected element sequence.
module tb_unpacker;

   localparam int W   = 16;
   localparam int BW  = 128;
   localparam int EPB = BW / W;
   localparam int BPE = W / 8;
   localparam int BIG = 1 << 30;

   typedef struct packed {
      logic [BW-1:0]   data;
      logic [BW/8-1:0] strb;
      logic            last;
   } beat_t;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } elem_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_valid [2];
   logic            s_ready [2];
   logic [BW-1:0]   s_data  [2];
   logic [BW/8-1:0] s_strb  [2];
   logic            s_last  [2];
   logic            m_valid [2];
   logic            m_ready [2];
   logic [W-1:0]    m_data  [2];
   logic            m_last  [2];
   logic            err     [2];

   beat_t beat_q[$];
   elem_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   always #5 clk = ~clk;

   unpacker #(.W(W), .BEAT_W(BW), .LSB_FIRST(1)) u_lsb (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
      .s_strb(s_strb[0]), .s_last(s_last[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
      .m_last(m_last[0]), .err(err[0])
   );

   unpacker #(.W(W), .BEAT_W(BW), .LSB_FIRST(0)) u_msb (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
      .s_strb(s_strb[1]), .s_last(s_last[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
      .m_last(m_last[1]), .err(err[1])
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit offset of slot k for the given slot order.
   function automatic int slot_bit(input bit lsb, input int k);
      return lsb ? k * W : BW - (k + 1) * W;
   endfunction

   // Pack a burst of n elements into beats exactly as a packer would, and
   // queue the element sequence itself as the expected output.
   task automatic push_burst(input int d, input int n, input logic [W-1:0] base, input bit rnd);
      logic [W-1:0] elems[$];
      beat_t        bt;
      for (int i = 0; i < n; i++) elems.push_back(rnd ? W'($urandom) : base + W'(i));
      for (int b = 0; b * EPB < n; b++) begin
         bt = '0;
         for (int k = 0; k < EPB && b * EPB + k < n; k++) begin
            bt.data[slot_bit(d == 0, k) +: W]       = elems[b * EPB + k];
            bt.strb[slot_bit(d == 0, k) / 8 +: BPE] = '1;
         end
         bt.last = ((b + 1) * EPB >= n);
         beat_q.push_back(bt);
      end
      for (int i = 0; i < n; i++) exp_q.push_back('{data: elems[i], last: (i == n - 1)});
   endtask

   // Queue a hand-built beat for the LSB-first instance; expected output is
   // the run of leading full slots, with last on the final one.
   task automatic push_raw(input logic [W-1:0] base, input logic [BW/8-1:0] strb, input bit last);
      beat_t bt;
      elem_t e;
      int    cnt = 0;
      bt = '0;
      for (int k = 0; k < EPB; k++) bt.data[slot_bit(1, k) +: W] = base + W'(k);
      bt.strb = strb;
      bt.last = last;
      beat_q.push_back(bt);
      for (int k = 0; k < EPB; k++) begin
         if (!(&strb[slot_bit(1, k) / 8 +: BPE])) break;
         exp_q.push_back('{data: base + W'(k), last: 1'b0});
         cnt++;
      end
      if (cnt > 0 && last) begin
         e      = exp_q.pop_back();
         e.last = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // Drive queued beats into instance d and score every presented element.
   // Stops when everything drains, after max_out consumed elements, or on budget.
   task automatic run(input int d, input int rdy_pct, input int max_out,
                      output int bubbles, output int srdy_emit);
      int outs     = 0;
      int cyc      = 0;
      bit offering = 1'b0;
      bit started  = 1'b0;
      bubbles   = 0;
      srdy_emit = 0;
      while ((exp_q.size() > 0 || beat_q.size() > 0) && outs < max_out && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         m_ready[d] = ($urandom_range(99) < rdy_pct);
         if (!offering && beat_q.size() > 0 && (rdy_pct == 100 || $urandom_range(3) != 0))
            offering = 1'b1;
         s_valid[d] = offering;
         if (offering) begin
            s_data[d] = beat_q[0].data;
            s_strb[d] = beat_q[0].strb;
            s_last[d] = beat_q[0].last;
         end
         #1;
         if (m_valid[d]) begin
            started = 1'b1;
            if (exp_q.size() == 0) begin
               check("spurious_valid", m_valid[d], 1'b0);
            end else begin
               check("m_data", m_data[d], exp_q[0].data);
               check("m_last", m_last[d], exp_q[0].last);
               if (m_ready[d]) begin
                  void'(exp_q.pop_front());
                  outs++;
               end
            end
            if (s_ready[d]) srdy_emit++;
         end else if (started && exp_q.size() > 0) begin
            bubbles++;
         end
         if (s_valid[d] && s_ready[d]) begin
            void'(beat_q.pop_front());
            offering = 1'b0;
         end
         @(posedge clk);
      end
      #1;
      s_valid[d] = 1'b0;
      m_ready[d] = 1'b0;
      if (outs < max_out) check("drain", exp_q.size() + beat_q.size(), 0);
   endtask

   initial begin
      int bub, srdy;
      for (int d = 0; d < 2; d++) begin
         s_valid[d] = 1'b0;
         s_data[d]  = '0;
         s_strb[d]  = '0;
         s_last[d]  = 1'b0;
         m_ready[d] = 1'b0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_s_ready", s_ready[d], 1'b1);
         check("rst_m_valid", m_valid[d], 1'b0);
         check("rst_m_data",  m_data[d],  '0);
         check("rst_err",     err[d],     1'b0);
      end

      // Full beat: eight elements on consecutive cycles, s_ready only on the last.
      push_burst(0, 8, 16'h1000, 1'b0);
      run(0, 100, BIG, bub, srdy);
      check("full_bubbles", bub, 0);
      check("full_sready",  srdy, 1);
      check("full_err",     err[0], 1'b0);

      // Partial beat: three elements, strobe 0x003F.
      push_burst(0, 3, 16'h2000, 1'b0);
      check("partial_strb", beat_q[0].strb, 16'h003F);
      run(0, 100, BIG, bub, srdy);
      check("partial_err", err[0], 1'b0);

      // Two full beats back-to-back: sixteen elements with no bubble.
      push_burst(0, 16, 16'h1000, 1'b0);
      run(0, 100, BIG, bub, srdy);
      check("b2b_bubbles", bub, 0);
      check("b2b_sready",  srdy, 2);
      check("b2b_err",     err[0], 1'b0);

      // Malformed strobes: 0x0037 yields slot 0 only, then an empty beat with
      // last is dropped on the back-to-back load.
      push_raw(16'h5000, 16'h0037, 1'b0);
      push_raw(16'h6000, 16'h0000, 1'b1);
      run(0, 100, BIG, bub, srdy);
      check("bad_err",    err[0],     1'b1);
      check("bad_idle",   m_valid[0], 1'b0);
      check("bad_sready", s_ready[0], 1'b1);

      // Reset after three of eight elements.
      push_burst(0, 8, 16'h3000, 1'b0);
      run(0, 100, 3, bub, srdy);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_m_valid", m_valid[0], 1'b0);
      check("midrst_m_last",  m_last[0],  1'b0);
      check("midrst_m_data",  m_data[0],  '0);
      exp_q.delete();
      beat_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("postrst_s_ready", s_ready[0], 1'b1);
      check("postrst_err",     err[0],     1'b0);
      check("postrst_m_valid", m_valid[0], 1'b0);
      push_burst(0, 8, 16'h4000, 1'b0);
      run(0, 100, BIG, bub, srdy);
      check("postrst_bubbles", bub, 0);

      // Random bursts with 75% m_ready, both slot orders.
      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 25; b++) push_burst(d, $urandom_range(20, 1), '0, 1'b1);
         run(d, 75, BIG, bub, srdy);
         check("rand_err",  err[d],     1'b0);
         check("rand_idle", m_valid[d], 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 Parameter W, default 16: element width in bits; SHALL be a multiple of 8, else elaboration error.
REQ-002 Parameter BEAT_W, default 128: beat width in bits; SHALL be a multiple of W, else elaboration error.
REQ-003 Parameter LSB_FIRST, default 1: 1 = slot 0 at bits [W-1:0]; 0 = slot 0 at bits [BEAT_W-1:BEAT_W-W].
REQ-004 Derived values: BYTES_PER_ELEM = W/8, BYTES_PER_BEAT = BEAT_W/8, ELS_PER_BEAT = BEAT_W/W.
REQ-005 Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  beat valid
- s_ready  out  1  beat accepted when s_valid && s_ready
- s_data  in  BEAT_W  packed beat
- s_strb  in  BYTES_PER_BEAT  byte strobes, same slot mapping as data
- s_last  in  1  final beat of burst
- m_valid  out  1  element valid
- m_ready  in  1  element consumed when m_valid && m_ready
- m_data  out  W  element
- m_last  out  1  final element of burst
- err  out  1  sticky malformed-strobe flag

Function
REQ-006 The block SHALL hold one beat register (data, strb, last) plus slot index idx and valid-slot count cnt.
REQ-007 Slot k byte range: LSB_FIRST=1 -> bytes k*BYTES_PER_ELEM upward; LSB_FIRST=0 -> bytes BYTES_PER_BEAT-(k+1)*BYTES_PER_ELEM upward. The bit range is the same range scaled by 8.
REQ-008 On beat accept, cnt SHALL be the number of leading slots, counted from slot 0, whose strobe slice is all ones. idx SHALL reset to 0.
REQ-009 The beat is malformed if cnt==0 or any strobe bit is set outside the leading cnt slots. A malformed beat SHALL set err, which stays 1 until reset.
REQ-010 State machine:
- EMPTY: s_ready=1, m_valid=0. A beat accept with cnt>0 goes to EMIT. A beat accept with cnt==0 drops the beat, stays in EMPTY and sets err; its s_last is discarded.
- EMIT: m_valid=1, m_data = slot idx of the held beat, m_last = held last && (idx==cnt-1).
REQ-011 In EMIT, on m_ready: if idx<cnt-1 then idx SHALL increment. Otherwise the beat is finished:
- if s_valid, the next beat SHALL load in the same cycle (s_ready=1 that cycle), giving zero bubble;
- else the state SHALL return to EMPTY.
REQ-012 s_ready SHALL be 1 in EMPTY, 1 in EMIT only when m_ready && idx==cnt-1, and 0 otherwise. It is combinational from state and m_ready.
REQ-013 Latency: beat accepted at edge N -> slot 0 presented with m_valid=1 after edge N. Sustained throughput SHALL be one element per cycle.
REQ-014 While m_valid && !m_ready, m_data, m_last and m_valid SHALL hold stable.
REQ-015 Output order SHALL be slot 0..cnt-1. Slots at index cnt and above SHALL never be emitted.
REQ-016 A back-to-back load of a malformed cnt==0 beat SHALL set err and go to EMPTY.
REQ-017 For any well-formed stream, the block SHALL exactly invert packer (same W, BEAT_W, LSB_FIRST): it reproduces the element sequence, with last on the final element.

Reset
REQ-018 On rst=1, immediately and asynchronously: state=EMPTY, m_valid=0, m_last=0, m_data=0, err=0, idx=0, cnt=0, beat register cleared.
REQ-019 Reset mid-beat SHALL discard remaining slots. After release, s_ready=1 and no stale element is emitted.

Verification
REQ-020 Scenarios (W=16, BEAT_W=128, LSB_FIRST=1 unless stated):
- Full beat, elements 0x1000..0x1007, strb 0xFFFF, s_last=1, m_ready=1 -> 0x1000..0x1007 on 8 consecutive cycles; m_last only with 0x1007; s_ready=0 on the 7 intermediate cycles.
- Partial beat, strb 0x003F, elements 0x2000..0x2002, s_last=1 -> 3 elements, m_last on 0x2002, err=0.
- Two full beats back-to-back, second with s_last, m_ready=1 -> 16 elements with no bubble; second beat accepted in the cycle 0x1007 is consumed.
- Random m_ready (75% high), bursts of 1..20 elements fed through packer into unpacker, both LSB_FIRST values -> output equals input sequence; outputs stable during stalls; m_last once per burst.
- strb 0x0037 -> only slot 0 emitted, err=1. Then strb 0x0000 with s_last -> no element, err stays 1.
- rst pulsed after 3 of 8 elements -> m_valid=0 during reset. After release: s_ready=1, err=0, and a new beat emits from its slot 0.
